// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if - control/status bundle for pc_sequencer.
//
// master : pipeline control side (drives stall/redirect/call/ret, observes pc and RAS flags)
// slave  : the sequencer itself
//
// Signals:
//   stall            hold PC
//   redirect_valid   load redirect_target
//   redirect_target  redirect destination (WIDTH bits)
//   call             with redirect_valid, push pc+INC as return address
//   ret              pop RAS top into PC
//   pc               registered current PC
//   pc_plus          pc+INC, mod 2^WIDTH
//   ras_empty        return-address stack holds no entries
//   ras_full         return-address stack holds RAS_DEPTH entries
//   ras_err          sticky underflow/overflow flag
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_err;

    modport master (
        output stall, redirect_valid, redirect_target, call, ret,
        input  pc, pc_plus, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, call, ret,
        output pc, pc_plus, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer - WIDTH-bit program counter with stall, redirect and an
// optional circular return-address stack (RAS).
//
// Ports:
//   clock  system clock; all state updates on the falling edge
//   reset  asynchronous, active-low
//   bus    pc_sequencer_if.slave (stall/redirect/call/ret in, pc/pc_plus/RAS flags out)
//
// Next-PC priority: redirect > ret (RAS non-empty) > stall > increment.
//
// Build option: define PC_RAS_EN to compile in the return-address stack.
// Without it call/ret are ignored and the RAS flags are tied
// (ras_empty=1, ras_full=0, ras_err=0).
module pc_sequencer #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      INC       = 1,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_plus;

    // Carry-out is discarded: the sum is truncated to WIDTH bits.
    assign pc_plus     = pc_reg + INC_W;
    assign bus.pc      = pc_reg;
    assign bus.pc_plus = pc_plus;

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            pc_reg <= RESET_VEC;
        end else begin
            pc_reg <= pc_next;
        end
    end

`ifdef PC_RAS_EN
    localparam int unsigned  PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             empty_reg;
    logic             full_reg;
    logic             err_reg;
    logic             err_next;
    logic             push;

    // The write pointer always points one past the most recent push, so the
    // top entry sits just below it (modulo depth).
    assign top_ptr = wr_ptr_reg - PTR_W'(1);

    always_comb begin
        pc_next     = pc_plus;
        push        = 1'b0;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        err_next    = err_reg;
        if (bus.redirect_valid) begin
            pc_next = bus.redirect_target;
            if (bus.call) begin
                push        = 1'b1;
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
                // A push on a full stack lands on the oldest slot; occupancy
                // stays saturated and the overflow is recorded.
                if (count_reg == FULL_CNT) begin
                    err_next = 1'b1;
                end else begin
                    count_next = count_reg + (PTR_W + 1)'(1);
                end
            end
        end else if (bus.ret && !empty_reg) begin
            pc_next     = ras_mem[top_ptr];
            wr_ptr_next = top_ptr;
            count_next  = count_reg - (PTR_W + 1)'(1);
        end else begin
            // A ret on an empty stack is an underflow; the PC then behaves
            // as if ret had not been asserted.
            if (bus.ret) begin
                err_next = 1'b1;
            end
            if (bus.stall) begin
                pc_next = pc_reg;
            end
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            empty_reg  <= 1'b1;
            full_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            empty_reg  <= (count_next == '0);
            full_reg   <= (count_next == FULL_CNT);
            err_reg    <= err_next;
        end
    end

    // Stack storage carries no reset; entries are only read when occupancy
    // says they are valid.
    always_ff @(negedge clock) begin
        if (reset && push) begin
            ras_mem[wr_ptr_reg] <= pc_plus;
        end
    end

    assign bus.ras_empty = empty_reg;
    assign bus.ras_full  = full_reg;
    assign bus.ras_err   = err_reg;
`else
    always_comb begin
        pc_next = pc_plus;
        if (bus.redirect_valid) begin
            pc_next = bus.redirect_target;
        end else if (bus.stall) begin
            pc_next = pc_reg;
        end
    end

    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
    assign bus.ras_err   = 1'b0;

    // call/ret have no effect without the stack.
    logic unused_ras_inputs;
    assign unused_ras_inputs = &{1'b0, bus.call, bus.ret};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer - directed, table-driven bench for pc_sequencer.
// Instance a: WIDTH=16, RESET_VEC=0x100, INC=1, RAS_DEPTH=4 (main checks).
// Instance b: WIDTH=8,  RESET_VEC=0xFE, free-running (wrap check).
// RAS vectors are used when PC_RAS_EN is defined, macro-off vectors otherwise.
module tb_pc_sequencer;
    logic clock = 1'b1;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pc_sequencer_if #(.WIDTH(16)) bus_a ();
    pc_sequencer_if #(.WIDTH(8))  bus_b ();

    pc_sequencer #(
        .WIDTH(16), .RESET_VEC(16'h0100), .INC(1), .RAS_DEPTH(4)
    ) u_dut_a (
        .clock(clock), .reset(reset), .bus(bus_a)
    );

    pc_sequencer #(
        .WIDTH(8), .RESET_VEC(8'hFE), .INC(1), .RAS_DEPTH(4)
    ) u_dut_b (
        .clock(clock), .reset(reset), .bus(bus_b)
    );

    typedef struct {
        logic        stall;
        logic        redir;
        logic [15:0] target;
        logic        call;
        logic        ret;
        logic [15:0] exp_pc;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic st, input logic rv, input logic [15:0] tg,
                                input logic cl, input logic rt, input logic [15:0] pc,
                                input logic em, input logic fu, input logic er);
        vec_t v;
        v.stall = st; v.redir = rv; v.target = tg; v.call = cl; v.ret = rt;
        v.exp_pc = pc; v.exp_empty = em; v.exp_full = fu; v.exp_err = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic rv, input logic [15:0] tg,
                         input logic cl, input logic rt);
        bus_a.stall           = st;
        bus_a.redirect_valid  = rv;
        bus_a.redirect_target = tg;
        bus_a.call            = cl;
        bus_a.ret             = rt;
    endtask

    // One active (falling) edge, then sample just after the following rising edge.
    task automatic step();
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus_b.stall = 1'b0; bus_b.redirect_valid = 1'b0; bus_b.redirect_target = '0;
        bus_b.call = 1'b0; bus_b.ret = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

        // Common vectors, starting from pc_a=0x102.
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0102, 1, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0102, 1, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0102, 1, 0, 0));
        vecs.push_back(mk(1, 1, 16'h0040, 0, 0, 16'h0040, 1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0041, 1, 0, 0));
`ifdef PC_RAS_EN
        // Nested call/return.
        vecs.push_back(mk(0, 1, 16'h0010, 0, 0, 16'h0010, 1, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0080, 1, 0, 16'h0080, 0, 0, 0));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0080 + 16'(i), 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'h00A0, 1, 0, 16'h00A0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'h00A0, 0, 1, 16'h00A0, 0, 0, 0)); // ret ignored under redirect
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0086, 0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0011, 1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0012, 1, 0, 0)); // call without redirect
        // Overflow: five calls from pc=1..5.
        vecs.push_back(mk(0, 1, 16'h0001, 0, 0, 16'h0001, 1, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0002, 1, 0, 16'h0002, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0003, 1, 0, 16'h0003, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0004, 1, 0, 16'h0004, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0005, 1, 0, 16'h0005, 0, 1, 0));
        vecs.push_back(mk(0, 1, 16'h0006, 1, 0, 16'h0006, 0, 1, 1));
        // Four pops return 6,5,4,3; then underflow falls through.
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0006, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0005, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0004, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0003, 1, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0004, 1, 0, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0004, 1, 0, 1));
`else
        vecs.push_back(mk(0, 1, 16'h0080, 1, 0, 16'h0080, 1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0081, 1, 0, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 16'h0081, 1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0082, 1, 0, 0));
`endif

        // Reset held while the clock runs.
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1;
        check("reset_pc", 32'(bus_a.pc), 32'h100);
        check("reset_empty", 32'(bus_a.ras_empty), 32'h1);
        check("reset_full", 32'(bus_a.ras_full), 32'h0);
        check("reset_err", 32'(bus_a.ras_err), 32'h0);
        check("reset_pc_b", 32'(bus_b.pc), 32'hFE);

        reset = 1'b1;
        #1;
        check("release_hold_pc", 32'(bus_a.pc), 32'h100);
        $display("txn release: pc_a=0x%0h pc_b=0x%0h", bus_a.pc, bus_b.pc);

        step();
        check("first_edge_pc", 32'(bus_a.pc), 32'h101);
        check("first_edge_plus", 32'(bus_a.pc_plus), 32'h102);
        check("wrap_pc_ff", 32'(bus_b.pc), 32'hFF);
        check("wrap_plus_00", 32'(bus_b.pc_plus), 32'h00);
        $display("txn edge1: pc_a=0x%0h pc_b=0x%0h", bus_a.pc, bus_b.pc);
        step();
        check("second_edge_pc", 32'(bus_a.pc), 32'h102);
        check("wrap_pc_00", 32'(bus_b.pc), 32'h00);
        check("wrap_plus_01", 32'(bus_b.pc_plus), 32'h01);
        $display("txn edge2: pc_a=0x%0h pc_b=0x%0h", bus_a.pc, bus_b.pc);

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].redir, vecs[i].target, vecs[i].call, vecs[i].ret);
            step();
            $display("txn vec%0d: st=%0b rv=%0b tg=0x%0h call=%0b ret=%0b -> pc=0x%0h e=%0b f=%0b err=%0b",
                     i, vecs[i].stall, vecs[i].redir, vecs[i].target, vecs[i].call, vecs[i].ret,
                     bus_a.pc, bus_a.ras_empty, bus_a.ras_full, bus_a.ras_err);
            check($sformatf("vec%0d_pc", i), 32'(bus_a.pc), 32'(vecs[i].exp_pc));
            check($sformatf("vec%0d_plus", i), 32'(bus_a.pc_plus), 32'(16'(vecs[i].exp_pc + 16'h1)));
            check($sformatf("vec%0d_empty", i), 32'(bus_a.ras_empty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d_full", i), 32'(bus_a.ras_full), 32'(vecs[i].exp_full));
            check($sformatf("vec%0d_err", i), 32'(bus_a.ras_err), 32'(vecs[i].exp_err));
        end

        // Asynchronous reset in the middle of a call/ret cycle, away from any edge.
        drive(1'b0, 1'b1, 16'h3333, 1'b1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_pc", 32'(bus_a.pc), 32'h100);
        check("async_reset_empty", 32'(bus_a.ras_empty), 32'h1);
        check("async_reset_full", 32'(bus_a.ras_full), 32'h0);
        check("async_reset_err", 32'(bus_a.ras_err), 32'h0);
        $display("txn async_reset: pc_a=0x%0h", bus_a.pc);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();
        check("post_reset_pc", 32'(bus_a.pc), 32'h101);
        $display("txn post_reset: pc_a=0x%0h", bus_a.pc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the SCU ISA pipeline. It replaces the fixed 32-bit PC register with a WIDTH-bit PC that supports sequential increment, stall, branch/jump redirect, and an optional circular return-address stack (RAS) for call/return. It feeds the instruction-memory address and the IF/ID pipeline register.

## Interface
Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VEC, 0, PC value loaded on reset (WIDTH bits).
- INC, 1, sequential increment added to PC each advance.
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2); used only with PC_RAS_EN.

Ports:
- clock  in  1  system clock; all state updates on the falling edge, matching the pipeline.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC (hazard stall).
- redirect_valid  in  1  load redirect_target (taken branch/jump/flush).
- redirect_target  in  WIDTH  redirect destination.
- call  in  1  with redirect_valid: push return address pc+INC.
- ret  in  1  pop RAS top into PC.
- pc  out  WIDTH  registered current PC.
- pc_plus  out  WIDTH  combinational pc+INC, mod 2^WIDTH.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_err  out  1  sticky: underflow (ret on empty) or overflow (push on full).

## Operation
- Next-PC priority, evaluated each falling edge, highest first:
  1. redirect_valid=1: pc ← redirect_target; if call=1, push pc+INC. ret ignored.
  2. ret=1 and RAS non-empty: pc ← RAS top; pop.
  3. stall=1: pc held.
  4. Otherwise: pc ← pc+INC.
- Redirect overrides stall (flush beats hazard hold).
- call without redirect_valid: ignored, no push.
- ret with RAS empty: no pop, ras_err ← 1, falls through to rule 3/4.
- Push when full: overwrites oldest entry (circular buffer), count stays RAS_DEPTH, ras_err ← 1, newest value becomes top.
- Increment arithmetic is mod 2^WIDTH; carry-out is discarded.
- RAS: write pointer plus occupancy count 0..RAS_DEPTH; top = most recent push still present.
- ras_err stays set until reset.

## Timing
- Reset (reset=0, any time, independent of clock): pc=RESET_VEC, RAS count=0, ras_empty=1, ras_full=0, ras_err=0. RAS entry contents are don't-care.
- Reset release: the first falling edge with reset=1 performs a normal update. pc=RESET_VEC remains visible until that edge.
- Latency: one falling edge from input to new pc. pc_plus follows pc combinationally in the same cycle.
- Inputs are sampled at the falling edge and must be stable around it.
- RAS flags are registered and update on the same edge as the push/pop.
- Reset asserted mid-call/ret: the operation is aborted and all state returns to reset values immediately.

## Configuration
- Macro: PC_RAS_EN.
- Defined: RAS logic compiled in, behaviour as above.
- Undefined: no RAS storage. call and ret are ignored (ret never changes pc). ras_empty tied 1, ras_full tied 0, ras_err tied 0. The priority chain is redirect > stall > increment.

## Test plan
- Reset: hold reset=0 with RESET_VEC=0x100 and toggle clock -> pc=0x100, ras_empty=1, ras_err=0. Release -> next edge pc=0x101 (INC=1).
- Increment/wrap: WIDTH=8, pc=0xFE, free-running -> pc goes 0xFF then 0x00, pc_plus=0x01.
- Stall vs redirect: stall=1 for 3 edges -> pc constant. Then stall=1 with redirect_valid=1, target=0x40 -> pc=0x40 on that edge.
- Call/return (PC_RAS_EN): at pc=0x10, call+redirect to 0x80. At 0x85, call+redirect to 0xA0. Then ret -> pc=0x86. Then ret -> pc=0x11. ras_empty=1, ras_err=0.
- Overflow/underflow: RAS_DEPTH=4, five calls from pc=1,2,3,4,5 -> ras_full=1, ras_err=1. Four rets return 6,5,4,3. Fifth ret -> no pop, pc increments.
- Macro off: call+redirect then ret -> pc follows redirect then increments, ras_empty=1, ras_err=0.
